// File: rtl/wb_queue.sv
// wb_queue: in-order writeback FIFO between the execute/load stages and the
// register file. It takes up to two results per cycle (load first, then ALU),
// coalesces a result that repeats the youngest entry's addr+pc, and issues one
// tagged register write per cycle. It also reports per-register pending hazards.
// Optional macro WBQ_BYPASS_EN: with an empty queue, a single incoming result
// goes straight to the write port in the same cycle and is not queued.
module wb_queue #(
   parameter int pw    = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alu_vld,
   input  logic [pw-1:0]            alu_addr,
   input  logic [7:0]               alu_dat,
   input  logic [11:0]              alu_pc,
   input  logic                     ld_vld,
   input  logic [pw-1:0]            ld_addr,
   input  logic [7:0]               ld_dat,
   input  logic [11:0]              ld_pc,
   output logic                     in_rdy,
   input  logic [pw-1:0]            rd_addrA,
   input  logic [pw-1:0]            rd_addrB,
   output logic                     hazA,
   output logic                     hazB,
   output logic                     wr_en,
   output logic [pw-1:0]            wr_addr,
   output logic [7:0]               wr_dat,
   output logic [11:0]              wr_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTRW = $clog2(DEPTH);
   localparam int CW   = PTRW + 1;

   typedef struct packed {
      logic [pw-1:0] addr;
      logic [7:0]    dat;
      logic [11:0]   pc;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PTRW-1:0] head, tail, young, off;
   logic            acc_ld, acc_alu, byp, pop, pair_merge, m0;
   entry_t          ld_e, alu_e, item0, item1;
   logic [1:0]      n_items, pushes;

   // Acceptance, pair/youngest-entry coalescing and push count
   always_comb begin
      ld_e       = '{addr: ld_addr, dat: ld_dat, pc: ld_pc};
      alu_e      = '{addr: alu_addr, dat: alu_dat, pc: alu_pc};
      in_rdy     = (count <= CW'(DEPTH - 2));
      acc_ld     = ld_vld & in_rdy;
      acc_alu    = alu_vld & in_rdy;
      pop        = (count != '0);
      young      = tail - 1'b1;
`ifdef WBQ_BYPASS_EN
      byp        = (count == '0) && (ld_vld ^ alu_vld);
`else
      byp        = 1'b0;
`endif
      pair_merge = acc_ld && acc_alu && (ld_addr == alu_addr) && (ld_pc == alu_pc);
      item0      = alu_e;
      item1      = alu_e;
      n_items    = 2'd0;
      if (!byp) begin
         if (acc_ld && acc_alu) begin
            if (pair_merge) begin
               n_items = 2'd1;
            end else begin
               item0   = ld_e;
               n_items = 2'd2;
            end
         end else if (acc_ld) begin
            item0   = ld_e;
            n_items = 2'd1;
         end else if (acc_alu) begin
            n_items = 2'd1;
         end
      end
      // Coalescing needs a youngest entry that survives this edge; with one
      // entry it is the head being written out now, so the input is queued.
      m0 = (n_items != 2'd0) && (count >= CW'(2)) &&
           (mem[young].addr == item0.addr) && (mem[young].pc == item0.pc);
      pushes = n_items - {1'b0, m0};
   end

   // Write port: queue head, or the bypassed input when the queue is empty
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_dat  = '0;
      wr_pc   = '0;
      if (pop) begin
         wr_en   = 1'b1;
         wr_addr = mem[head].addr;
         wr_dat  = mem[head].dat;
         wr_pc   = mem[head].pc;
      end else if (byp) begin
         wr_en   = 1'b1;
         wr_addr = ld_vld ? ld_addr : alu_addr;
         wr_dat  = ld_vld ? ld_dat  : alu_dat;
         wr_pc   = ld_vld ? ld_pc   : alu_pc;
      end
   end

   // Hazards: any live entry or any input accepted this cycle
   always_comb begin
      hazA = (acc_ld && ld_addr == rd_addrA) || (acc_alu && alu_addr == rd_addrA);
      hazB = (acc_ld && ld_addr == rd_addrB) || (acc_alu && alu_addr == rd_addrB);
      off  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         off = PTRW'(i) - head;
         if ({1'b0, off} < count) begin
            if (mem[i].addr == rd_addrA) hazA = 1'b1;
            if (mem[i].addr == rd_addrB) hazB = 1'b1;
         end
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (pop) head <= head + 1'b1;
         tail  <= tail + PTRW'(pushes);
         count <= count + CW'(pushes) - CW'(pop);
      end
   end

   // Entry storage; validity is tracked by count so contents need no reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (m0) begin
            mem[young].dat <= item0.dat;
            if (n_items == 2'd2) mem[tail] <= item1;
         end else begin
            if (n_items != 2'd0) mem[tail] <= item0;
            if (n_items == 2'd2) mem[tail + 1'b1] <= item1;
         end
      end
   end

endmodule
